// File: rtl/fb_scan_arbiter.sv
// Framebuffer port arbiter for the 160x120 3-bit framebuffer in the pixel clock domain.
// Scan-out reads own every fourth active cycle; all other cycles drain a small write FIFO.
module fb_scan_arbiter #(
    parameter int unsigned SRC_W      = 160,
    parameter int unsigned SRC_H      = 120,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned PIX_W      = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_pixel,
    input  logic              sys_resetn,
    input  logic [9:0]        cx,
    input  logic [9:0]        cy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_rgb,
    output logic              pix_valid,
    output logic [15:0]       drop_count
);

    localparam logic [9:0]        ActW   = 10'(SRC_W << SCALE_LOG2);
    localparam logic [9:0]        ActH   = 10'(SRC_H << SCALE_LOG2);
    localparam logic [ADDR_W-1:0] FbSize = ADDR_W'(SRC_W * SRC_H);
    localparam int unsigned       PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned       CntW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0]   Full   = CntW'(FIFO_DEPTH);

    // Raster decode
    logic              in_active;
    logic              read_slot;
    logic [ADDR_W-1:0] rd_addr;

    assign in_active = (cx < ActW) && (cy < ActH);
    assign read_slot = in_active && (cx[SCALE_LOG2-1:0] == '0);
    assign rd_addr   = ADDR_W'(cy >> SCALE_LOG2) * ADDR_W'(SRC_W) + ADDR_W'(cx >> SCALE_LOG2);

    // Write FIFO
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [PIX_W-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;
    logic              wr_accept, addr_ok, push, pop, drop;
    logic [15:0]       drop_q;

    assign wr_ready  = (count_q != Full);
    assign wr_accept = wr_valid && wr_ready;
    assign addr_ok   = (wr_addr < FbSize);
    assign push      = wr_accept && addr_ok;
    assign drop      = wr_accept && !addr_ok;
    assign pop       = !read_slot && (count_q != '0);

    // FIFO storage needs no reset: an entry is only read after it was written
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= wr_addr;
            fifo_data_q[wptr_q] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged
    always_ff @(posedge clk_pixel or negedge sys_resetn) begin
        if (!sys_resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Saturating count of writes rejected for an out-of-range address
    always_ff @(posedge clk_pixel or negedge sys_resetn) begin
        if (!sys_resetn) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;

    // RAM port mux: scan read wins, otherwise drain the FIFO head.
    // Gated by reset so the port is idle while held in reset, even over a read slot.
    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sys_resetn) begin
            if (read_slot) begin
                mem_ce   = 1'b1;
                mem_addr = rd_addr;
            end else if (pop) begin
                mem_ce    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_addr_q[rptr_q];
                mem_wdata = fifo_data_q[rptr_q];
            end
        end
    end

    // Scan pipeline: stage 1 tracks the cycle whose read data is arriving,
    // stage 2 aligns the active flag with the hold register
    logic             act_s1_q, rs_s1_q, act_s2_q;
    logic [PIX_W-1:0] hold_q;

    // Capture read data the cycle after a read slot and delay the active flag two cycles
    always_ff @(posedge clk_pixel or negedge sys_resetn) begin
        if (!sys_resetn) begin
            act_s1_q <= 1'b0;
            rs_s1_q  <= 1'b0;
            act_s2_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            act_s1_q <= in_active;
            rs_s1_q  <= read_slot;
            act_s2_q <= act_s1_q;
            if (rs_s1_q) hold_q <= mem_rdata;
        end
    end

    assign pix_valid = act_s2_q;
    assign pix_rgb   = act_s2_q ? hold_q : '0;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Bench for fb_scan_arbiter: RAM device model, reference model of the arbiter, directed raster.
module tb_fb_scan_arbiter;

    logic        clk_pixel = 1'b0;
    logic        sys_resetn;
    logic [9:0]  cx, cy;
    logic        wr_valid, wr_ready;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        mem_ce, mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata, mem_rdata;
    logic [2:0]  pix_rgb;
    logic        pix_valid;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;
    int frame = 0;

    always #5 clk_pixel = ~clk_pixel;

    fb_scan_arbiter dut (
        .clk_pixel (clk_pixel),
        .sys_resetn(sys_resetn),
        .cx        (cx),
        .cy        (cy),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_rgb   (pix_rgb),
        .pix_valid (pix_valid),
        .drop_count(drop_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Synchronous single-port RAM, preloaded with addr mod 8
    logic [2:0] ram [0:32767];
    initial begin
        logic        r_ce, r_we;
        logic [14:0] r_a;
        logic [2:0]  r_d;
        for (int i = 0; i < 32768; i++) ram[i] = 3'(i % 8);
        mem_rdata = 3'd0;
        forever begin
            @(negedge clk_pixel);
            r_ce = mem_ce; r_we = mem_we; r_a = mem_addr; r_d = mem_wdata;
            @(posedge clk_pixel);
            if (r_ce && r_we) ram[r_a] = r_d;
            else if (r_ce)    mem_rdata <= ram[r_a];
        end
    end

    // Reference model: picture of framebuffer contents, pending-write queue, 2-cycle display delay
    typedef struct {
        int a;
        int d;
    } wr_t;

    initial begin
        logic [2:0] fb_m [0:32767];
        wr_t q[$];
        wr_t h;
        int  cur_val, pv0, pv1, pr0, pr1, drops;
        int  cxd1, cxd2, cyd1, cyd2;
        int  x, y, a, act, rs;
        int  e_ce, e_we, e_addr, e_wdata, e_ready;
        for (int i = 0; i < 32768; i++) fb_m[i] = 3'(i % 8);
        cur_val = 0; pv0 = 0; pv1 = 0; pr0 = 0; pr1 = 0; drops = 0;
        cxd1 = 1023; cxd2 = 1023; cyd1 = 1023; cyd2 = 1023;
        forever begin
            @(negedge clk_pixel);
            if (!sys_resetn) begin
                q.delete();
                cur_val = 0; pv0 = 0; pv1 = 0; pr0 = 0; pr1 = 0; drops = 0;
                cxd1 = 1023; cxd2 = 1023; cyd1 = 1023; cyd2 = 1023;
                chk("rst_mem_ce", 32'(mem_ce), 0);
                chk("rst_mem_we", 32'(mem_we), 0);
                chk("rst_mem_addr", 32'(mem_addr), 0);
                chk("rst_mem_wdata", 32'(mem_wdata), 0);
                chk("rst_pix_rgb", 32'(pix_rgb), 0);
                chk("rst_pix_valid", 32'(pix_valid), 0);
                chk("rst_drop_count", 32'(drop_count), 0);
                chk("rst_wr_ready", 32'(wr_ready), 1);
            end else begin
                x   = int'(cx);
                y   = int'(cy);
                act = (x < 640 && y < 480) ? 1 : 0;
                rs  = (act == 1 && x % 4 == 0) ? 1 : 0;
                a   = (y / 4) * 160 + x / 4;
                e_ce = 0; e_we = 0; e_addr = 0; e_wdata = 0;
                if (rs == 1) begin
                    e_ce = 1; e_addr = a;
                end else if (q.size() > 0) begin
                    e_ce = 1; e_we = 1; e_addr = q[0].a; e_wdata = q[0].d;
                end
                e_ready = (q.size() < 4) ? 1 : 0;
                chk("mem_ce", 32'(mem_ce), e_ce);
                chk("mem_we", 32'(mem_we), e_we);
                chk("mem_addr", 32'(mem_addr), e_addr);
                chk("mem_wdata", 32'(mem_wdata), e_wdata);
                chk("wr_ready", 32'(wr_ready), e_ready);
                chk("pix_valid", 32'(pix_valid), pv1);
                chk("pix_rgb", 32'(pix_rgb), pr1);
                chk("drop_count", 32'(drop_count), (drops > 65535) ? 65535 : drops);
                // Hand-computed anchors for the model
                if (rs == 1) chk("no_we_in_read_slot", 32'(mem_we), 0);
                if (frame == 1 && cyd2 <= 3 && cxd2 <= 3) chk("pin_origin", 32'(pix_rgb), 0);
                if (frame == 1 && cyd2 == 0 && cxd2 == 4) chk("pin_cx4", 32'(pix_rgb), 1);
                if (frame == 1 && cyd2 == 479 && cxd2 == 636) chk("pin_last", 32'(pix_rgb), 7);
                if (frame == 2 && cyd2 >= 4 && cyd2 <= 7 && cxd2 >= 4 && cxd2 <= 7)
                    chk("pin_wr161", 32'(pix_rgb), 5);
                if (cxd2 >= 640 && cxd2 < 1023) chk("pin_hblank", 32'(pix_valid), 0);
                if (cyd2 == 480) chk("pin_vblank", 32'(pix_valid), 0);
                // Advance to the next cycle
                if (rs == 1) cur_val = int'(fb_m[a]);
                pv1 = pv0; pr1 = pr0;
                pv0 = act; pr0 = (act == 1) ? cur_val : 0;
                cxd2 = cxd1; cxd1 = x; cyd2 = cyd1; cyd1 = y;
                if (rs == 0 && q.size() > 0) begin
                    h = q.pop_front();
                    fb_m[h.a] = 3'(h.d);
                end
                if (wr_valid && e_ready == 1) begin
                    if (int'(wr_addr) < 19200) q.push_back('{a: int'(wr_addr), d: int'(wr_data)});
                    else drops++;
                end
            end
        end
    end

    // One cycle: inputs applied just after the rising edge, return just after the falling edge
    task automatic cyc(input int x, input int y, input logic rn, input logic wv,
                       input int wa, input int wd);
        @(posedge clk_pixel);
        #1;
        cx = 10'(x); cy = 10'(y); sys_resetn = rn;
        wr_valid = wv; wr_addr = 15'(wa); wr_data = 3'(wd);
        @(negedge clk_pixel);
        #1;
    endtask

    task automatic line(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) cyc(x, y, 1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        int k, saw_nr, kl, e;
        cx = '0; cy = '0; sys_resetn = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset held over a read-slot position
        for (int i = 0; i < 3; i++) cyc(0, 0, 1'b0, 1'b0, 0, 0);
        chk("init_mem_ce", 32'(mem_ce), 0);
        chk("init_wr_ready", 32'(wr_ready), 1);
        chk("init_pix_valid", 32'(pix_valid), 0);
        chk("init_drop_count", 32'(drop_count), 0);

        // Frame 1: top lines and the last active line
        frame = 1;
        for (int y = 0; y < 8; y++) line(y, 0, 659);
        line(479, 0, 659);

        // Blanking: single write, then two out-of-range writes
        cyc(0, 480, 1'b1, 1'b1, 161, 5);
        cyc(1, 480, 1'b1, 1'b0, 0, 0);
        chk("wr161_we", 32'(mem_we), 1);
        chk("wr161_addr", 32'(mem_addr), 161);
        chk("wr161_data", 32'(mem_wdata), 5);
        cyc(2, 480, 1'b1, 1'b0, 0, 0);
        chk("wr161_once", 32'(mem_we), 0);
        cyc(3, 480, 1'b1, 1'b1, 19200, 1);
        cyc(4, 480, 1'b1, 1'b1, 32767, 2);
        cyc(5, 480, 1'b1, 1'b0, 0, 0);
        chk("drop_two", 32'(drop_count), 2);
        chk("drop_ready", 32'(wr_ready), 1);
        chk("drop_no_we", 32'(mem_we), 0);
        line(480, 6, 659);

        // Frame 2: the written pixel shows on display lines 4..7
        frame = 2;
        for (int y = 4; y < 8; y++) line(y, 0, 659);

        // Back-to-back writes in the active area, some addresses written twice
        frame = 3;
        k = 0; saw_nr = 0;
        for (int x = 0; x < 660; x++) begin
            if (k < 16) begin
                cyc(x, 8, 1'b1, 1'b1, 10000 + k % 10, (k * 3 + 1) % 8);
                if (wr_ready) k++;
                else saw_nr = 1;
            end else begin
                cyc(x, 8, 1'b1, 1'b0, 0, 0);
            end
        end
        chk("ready_dropped", saw_nr, 1);
        chk("all_pushed", k, 16);
        for (int a = 0; a < 10; a++) begin
            kl = (a < 6) ? a + 10 : a;
            e  = (kl * 3 + 1) % 8;
            chk("order", 32'(ram[10000 + a]), e);
        end

        // Reset mid-line with writes queued, released on a read slot
        frame = 4;
        for (int x = 0; x < 20; x++) cyc(x, 9, 1'b1, 1'b1, 12000 + x, x % 8);
        cyc(20, 9, 1'b0, 1'b0, 0, 0);
        chk("midrst_mem_ce", 32'(mem_ce), 0);
        chk("midrst_mem_we", 32'(mem_we), 0);
        chk("midrst_pix_valid", 32'(pix_valid), 0);
        chk("midrst_pix_rgb", 32'(pix_rgb), 0);
        for (int x = 21; x < 24; x++) cyc(x, 9, 1'b0, 1'b0, 0, 0);
        cyc(24, 9, 1'b1, 1'b0, 0, 0);
        chk("release_ready", 32'(wr_ready), 1);
        chk("release_read", 32'(mem_ce), 1);
        cyc(25, 9, 1'b1, 1'b0, 0, 0);
        chk("release_no_stale_we", 32'(mem_we), 0);
        line(9, 26, 659);
        line(10, 0, 659);
        chk("stale_write_lost", 32'(ram[12000]), 12000 % 8 == 0 ? 0 : 32'(ram[12000]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
